mem_arbiter_multi: RTL and testbench

MEM_ARBITER_MULTI -- requirements
Module: mem_arbiter_multi

---
 rtl/mem_arbiter_multi.sv | 138 +++++++++++++
 tb/tb_mem_arbiter_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_multi.sv
// Multi-port memory arbiter: N requesters share one downstream memory port.
// Fixed or rotating priority, with bus lock that keeps the last acked port on the bus.
module mem_arbiter_multi #(
   parameter int NUM_PORTS   = 3,
   parameter int ADDR_WIDTH  = 19,
   parameter int DATA_WIDTH  = 16,
   parameter int ROUND_ROBIN = 1,
   localparam int IDX_W      = $clog2(NUM_PORTS),
   localparam int BSEL_W     = DATA_WIDTH / 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS-1:0]            m_access,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] m_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] m_data_out,
   input  logic [NUM_PORTS-1:0]            m_wr_en,
   input  logic [NUM_PORTS*BSEL_W-1:0]     m_bytesel,
   input  logic [NUM_PORTS-1:0]            m_lock,
   output logic [NUM_PORTS-1:0]            m_ack,
   output logic [DATA_WIDTH-1:0]           m_data_in,
   output logic [ADDR_WIDTH-1:0]           q_m_addr,
   output logic [DATA_WIDTH-1:0]           q_m_data_out,
   output logic                            q_m_wr_en,
   output logic [BSEL_W-1:0]               q_m_bytesel,
   output logic                            q_m_access,
   input  logic                            q_m_ack,
   input  logic [DATA_WIDTH-1:0]           q_m_data_in,
   output logic                            grant_valid,
   output logic [IDX_W-1:0]                grant_idx
);

   // Handshake: a port holds m_access until its m_ack pulse; downstream holds
   // q_m_access until q_m_ack. Dropping m_access while granted aborts the access.
   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] grant_next;
   logic [IDX_W-1:0] last_granted, last_next;
   logic             lock_valid, lock_next;
   logic [IDX_W-1:0] winner;
   logic             any_req;
   logic             lock_req;
   logic             sel_access;
   logic             active;

   assign m_data_in   = q_m_data_in;
   assign grant_valid = (state == BUSY) && reset;

   // Winner search; the rotating loop runs from the farthest slot down so the
   // nearest requester after last_granted is the last assignment to stick.
   always_comb begin
      winner   = '0;
      any_req  = |m_access;
      lock_req = 1'b0;
      if (ROUND_ROBIN != 0) begin
         for (int k = NUM_PORTS; k >= 1; k--) begin
            int idx;
            idx = (int'(last_granted) + k) % NUM_PORTS;
            if (m_access[idx]) winner = IDX_W'(idx);
         end
      end else begin
         for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (m_access[i]) winner = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (last_granted == IDX_W'(i) && m_access[i] && lock_valid) lock_req = 1'b1;
      end
      if (lock_req) winner = last_granted;
   end

   // Downstream mux from the granted port.
   always_comb begin
      sel_access   = 1'b0;
      q_m_addr     = '0;
      q_m_data_out = '0;
      q_m_wr_en    = 1'b0;
      q_m_bytesel  = '0;
      m_ack        = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_idx == IDX_W'(i)) sel_access = m_access[i];
      end
      active     = grant_valid && sel_access;
      q_m_access = active;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (active && grant_idx == IDX_W'(i)) begin
            q_m_addr     = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            q_m_data_out = m_data_out[i*DATA_WIDTH +: DATA_WIDTH];
            q_m_wr_en    = m_wr_en[i];
            q_m_bytesel  = m_bytesel[i*BSEL_W +: BSEL_W];
            m_ack[i]     = q_m_ack;
         end
      end
   end

   always_comb begin
      state_next = state;
      grant_next = grant_idx;
      last_next  = last_granted;
      lock_next  = lock_valid;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_next = BUSY;
               grant_next = winner;
            end
         end
         BUSY: begin
            if (!sel_access) begin
               state_next = IDLE;
            end else if (q_m_ack) begin
               state_next = IDLE;
               last_next  = grant_idx;
               lock_next  = 1'b0;
               for (int i = 0; i < NUM_PORTS; i++) begin
                  if (grant_idx == IDX_W'(i)) lock_next = m_lock[i];
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         grant_idx    <= '0;
         last_granted <= IDX_W'(NUM_PORTS - 1);
         lock_valid   <= 1'b0;
      end else begin
         state        <= state_next;
         grant_idx    <= grant_next;
         last_granted <= last_next;
         lock_valid   <= lock_next;
      end
   end

endmodule

// File: tb/tb_mem_arbiter_multi.sv
// Directed bench for mem_arbiter_multi: a rotating-priority instance plus a
// fixed-priority instance sharing the same requester stimulus.
module tb_mem_arbiter_multi;

   localparam int NP = 3;
   localparam int AW = 19;
   localparam int DW = 16;
   localparam int BW = DW / 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [NP-1:0]     m_access;
   logic [NP*AW-1:0]  m_addr;
   logic [NP*DW-1:0]  m_data_out;
   logic [NP-1:0]     m_wr_en;
   logic [NP*BW-1:0]  m_bytesel;
   logic [NP-1:0]     m_lock;
   logic              q_m_ack;
   logic [DW-1:0]     q_m_data_in;

   logic [NP-1:0]     rr_m_ack, fx_m_ack;
   logic [DW-1:0]     rr_m_data_in, fx_m_data_in;
   logic [AW-1:0]     rr_q_m_addr, fx_q_m_addr;
   logic [DW-1:0]     rr_q_m_data_out, fx_q_m_data_out;
   logic              rr_q_m_wr_en, fx_q_m_wr_en;
   logic [BW-1:0]     rr_q_m_bytesel, fx_q_m_bytesel;
   logic              rr_q_m_access, fx_q_m_access;
   logic              rr_grant_valid, fx_grant_valid;
   logic [1:0]        rr_grant_idx, fx_grant_idx;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_arbiter_multi #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1)) dut_rr (
      .clk(clk), .reset(reset), .m_access(m_access), .m_addr(m_addr),
      .m_data_out(m_data_out), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel), .m_lock(m_lock),
      .m_ack(rr_m_ack), .m_data_in(rr_m_data_in), .q_m_addr(rr_q_m_addr),
      .q_m_data_out(rr_q_m_data_out), .q_m_wr_en(rr_q_m_wr_en), .q_m_bytesel(rr_q_m_bytesel),
      .q_m_access(rr_q_m_access), .q_m_ack(q_m_ack), .q_m_data_in(q_m_data_in),
      .grant_valid(rr_grant_valid), .grant_idx(rr_grant_idx)
   );

   mem_arbiter_multi #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0)) dut_fx (
      .clk(clk), .reset(reset), .m_access(m_access), .m_addr(m_addr),
      .m_data_out(m_data_out), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel), .m_lock(m_lock),
      .m_ack(fx_m_ack), .m_data_in(fx_m_data_in), .q_m_addr(fx_q_m_addr),
      .q_m_data_out(fx_q_m_data_out), .q_m_wr_en(fx_q_m_wr_en), .q_m_bytesel(fx_q_m_bytesel),
      .q_m_access(fx_q_m_access), .q_m_ack(q_m_ack), .q_m_data_in(q_m_data_in),
      .grant_valid(fx_grant_valid), .grant_idx(fx_grant_idx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One grant on the rotating instance: granted one edge after the request,
   // ack mirrored onto that port only, then one IDLE cycle.
   task automatic expect_grant(input int exp_idx, input bit also_fx, input string tag);
      tick();
      chk({tag, "_valid"}, 32'(rr_grant_valid), 32'd1);
      chk({tag, "_idx"}, 32'(rr_grant_idx), 32'(exp_idx));
      chk({tag, "_qacc"}, 32'(rr_q_m_access), 32'd1);
      if (also_fx) chk({tag, "_fx_idx"}, 32'(fx_grant_idx), 32'(exp_idx));
      q_m_ack = 1'b1;
      #1;
      chk({tag, "_ack"}, 32'(rr_m_ack), 32'(1 << exp_idx));
      tick();
      q_m_ack = 1'b0;
      #1;
      chk({tag, "_idle"}, 32'(rr_grant_valid), 32'd0);
   endtask

   initial begin
      reset       = 1'b0;
      m_access    = '0;
      m_addr      = '0;
      m_data_out  = '0;
      m_wr_en     = '0;
      m_bytesel   = '0;
      m_lock      = '0;
      q_m_ack     = 1'b0;
      q_m_data_in = 16'h0000;

      // Reset: outputs quiet even with requests and a stray downstream ack.
      tick();
      m_access = 3'b111;
      q_m_ack  = 1'b1;
      tick();
      chk("rst_valid", 32'(rr_grant_valid), 32'd0);
      chk("rst_idx", 32'(rr_grant_idx), 32'd0);
      chk("rst_qacc", 32'(rr_q_m_access), 32'd0);
      chk("rst_ack", 32'(rr_m_ack), 32'd0);
      chk("rst_addr", 32'(rr_q_m_addr), 32'd0);
      q_m_data_in = 16'hA5C3;
      #1;
      chk("rdata_pass", 32'(rr_m_data_in), 32'hA5C3);
      m_access = '0;
      q_m_ack  = 1'b0;
      reset    = 1'b1;
      tick();

      // Ports 0 and 2 together: port 0 first, then port 2 after an IDLE cycle.
      m_access = 3'b101;
      q_m_ack  = 1'b1;
      #1;
      chk("idle_ack_ignored", 32'(rr_m_ack), 32'd0);
      q_m_ack  = 1'b0;
      expect_grant(0, 1'b1, "fix_p0");
      m_access = 3'b100;
      expect_grant(2, 1'b1, "fix_p2");
      m_access = 3'b000;
      tick();

      // Everyone requesting continuously: 0,1,2,0,1,2.
      m_access = 3'b111;
      for (int i = 0; i < 6; i++) expect_grant(i % 3, 1'b0, "rr_seq");
      m_access = 3'b000;
      tick();

      // Port 1 write passes straight through.
      m_addr[AW +: AW]       = 19'h12345;
      m_data_out[DW +: DW]   = 16'hBEEF;
      m_bytesel[BW +: BW]    = 2'b10;
      m_wr_en[1]             = 1'b1;
      m_access               = 3'b010;
      tick();
      chk("wr_idx", 32'(rr_grant_idx), 32'd1);
      chk("wr_addr", 32'(rr_q_m_addr), 32'h12345);
      chk("wr_data", 32'(rr_q_m_data_out), 32'hBEEF);
      chk("wr_en", 32'(rr_q_m_wr_en), 32'd1);
      chk("wr_bsel", 32'(rr_q_m_bytesel), 32'h2);
      chk("wr_ack_before", 32'(rr_m_ack), 32'd0);
      q_m_ack = 1'b1;
      #1;
      chk("wr_ack", 32'(rr_m_ack), 32'b010);
      tick();
      q_m_ack    = 1'b0;
      m_access   = 3'b000;
      m_wr_en    = '0;
      #1;
      chk("post_addr", 32'(rr_q_m_addr), 32'd0);
      chk("post_wr_en", 32'(rr_q_m_wr_en), 32'd0);
      m_addr     = '0;
      m_data_out = '0;
      m_bytesel  = '0;
      tick();

      // Lock held by port 2 keeps it on the bus; rotation resumes at 0 after release.
      m_access = 3'b111;
      m_lock   = 3'b100;
      expect_grant(2, 1'b0, "lock_a");
      expect_grant(2, 1'b0, "lock_b");
      m_lock   = 3'b000;
      expect_grant(2, 1'b0, "lock_c");
      expect_grant(0, 1'b0, "unlock");
      m_access = 3'b000;
      tick();

      // Abort: port 1 drops before the ack; its rotation slot is kept.
      m_access = 3'b110;
      tick();
      chk("abort_idx", 32'(rr_grant_idx), 32'd1);
      m_access = 3'b100;
      q_m_ack  = 1'b1;
      #1;
      chk("abort_qacc", 32'(rr_q_m_access), 32'd0);
      chk("abort_ack", 32'(rr_m_ack), 32'd0);
      tick();
      q_m_ack  = 1'b0;
      #1;
      chk("abort_idle", 32'(rr_grant_valid), 32'd0);
      m_access = 3'b110;
      expect_grant(1, 1'b0, "abort_retry");
      m_access = 3'b000;
      tick();

      // Reset in the middle of a BUSY period.
      m_access = 3'b111;
      tick();
      chk("mid_busy_idx", 32'(rr_grant_idx), 32'd2);
      reset = 1'b0;
      tick();
      chk("mid_rst_valid", 32'(rr_grant_valid), 32'd0);
      chk("mid_rst_qacc", 32'(rr_q_m_access), 32'd0);
      chk("mid_rst_ack", 32'(rr_m_ack), 32'd0);
      reset = 1'b1;
      expect_grant(0, 1'b0, "after_rst");
      m_access = 3'b000;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
